// File: rtl/tetris_pkg.sv
// Shared types for the falling-tile datapath: tile kinds, board points, cell
// offsets and the shape table giving each tile's four cells per rotation.
package tetris_pkg;

  typedef enum logic [2:0] {eNon, eI, eO, eT, eS, eZ, eJ, eL} tile_type_e;

  typedef struct packed {
    logic [7:0] x;
    logic [7:0] y;
  } point_t;

  typedef struct packed {
    logic signed [2:0] dx;
    logic signed [2:0] dy;
  } offset_t;

  typedef enum logic {eIDLE, eUPDATE} state_e;

  function automatic offset_t ofs(int dx, int dy);
    offset_t o;
    o.dx = 3'(dx);
    o.dy = 3'(dy);
    return o;
  endfunction

  // Indexed [type][angle][idx]; y grows downward, each angle is the previous
  // one rotated a quarter turn about the pivot.
  localparam offset_t shape_table_lp [8][4][4] = '{
    '{'{ofs( 0, 0), ofs( 0, 0), ofs( 0, 0), ofs( 0, 0)},
      '{ofs( 0, 0), ofs( 0, 0), ofs( 0, 0), ofs( 0, 0)},
      '{ofs( 0, 0), ofs( 0, 0), ofs( 0, 0), ofs( 0, 0)},
      '{ofs( 0, 0), ofs( 0, 0), ofs( 0, 0), ofs( 0, 0)}},
    '{'{ofs(-1, 0), ofs( 0, 0), ofs( 1, 0), ofs( 2, 0)},
      '{ofs( 0,-1), ofs( 0, 0), ofs( 0, 1), ofs( 0, 2)},
      '{ofs( 1, 0), ofs( 0, 0), ofs(-1, 0), ofs(-2, 0)},
      '{ofs( 0, 1), ofs( 0, 0), ofs( 0,-1), ofs( 0,-2)}},
    '{'{ofs( 0, 0), ofs( 1, 0), ofs( 0, 1), ofs( 1, 1)},
      '{ofs( 0, 0), ofs( 0, 1), ofs(-1, 0), ofs(-1, 1)},
      '{ofs( 0, 0), ofs(-1, 0), ofs( 0,-1), ofs(-1,-1)},
      '{ofs( 0, 0), ofs( 0,-1), ofs( 1, 0), ofs( 1,-1)}},
    '{'{ofs(-1, 0), ofs( 0, 0), ofs( 1, 0), ofs( 0, 1)},
      '{ofs( 0,-1), ofs( 0, 0), ofs( 0, 1), ofs(-1, 0)},
      '{ofs( 1, 0), ofs( 0, 0), ofs(-1, 0), ofs( 0,-1)},
      '{ofs( 0, 1), ofs( 0, 0), ofs( 0,-1), ofs( 1, 0)}},
    '{'{ofs( 0, 0), ofs( 1, 0), ofs(-1, 1), ofs( 0, 1)},
      '{ofs( 0, 0), ofs( 0, 1), ofs(-1,-1), ofs(-1, 0)},
      '{ofs( 0, 0), ofs(-1, 0), ofs( 1,-1), ofs( 0,-1)},
      '{ofs( 0, 0), ofs( 0,-1), ofs( 1, 1), ofs( 1, 0)}},
    '{'{ofs(-1, 0), ofs( 0, 0), ofs( 0, 1), ofs( 1, 1)},
      '{ofs( 0,-1), ofs( 0, 0), ofs(-1, 0), ofs(-1, 1)},
      '{ofs( 1, 0), ofs( 0, 0), ofs( 0,-1), ofs(-1,-1)},
      '{ofs( 0, 1), ofs( 0, 0), ofs( 1, 0), ofs( 1,-1)}},
    '{'{ofs(-1, 0), ofs( 0, 0), ofs( 1, 0), ofs( 1, 1)},
      '{ofs( 0,-1), ofs( 0, 0), ofs( 0, 1), ofs(-1, 1)},
      '{ofs( 1, 0), ofs( 0, 0), ofs(-1, 0), ofs(-1,-1)},
      '{ofs( 0, 1), ofs( 0, 0), ofs( 0,-1), ofs( 1,-1)}},
    '{'{ofs(-1, 0), ofs( 0, 0), ofs( 1, 0), ofs(-1, 1)},
      '{ofs( 0,-1), ofs( 0, 0), ofs( 0, 1), ofs(-1,-1)},
      '{ofs( 1, 0), ofs( 0, 0), ofs(-1, 0), ofs( 1,-1)},
      '{ofs( 0, 1), ofs( 0, 0), ofs( 0,-1), ofs( 1, 1)}}
  };

  function automatic offset_t tile_cell_offset(tile_type_e t, logic [1:0] a, logic [1:0] i);
    return shape_table_lp[t][a][i];
  endfunction

  // Per-axis modulo-256 add; negative offsets wrap to large values.
  function automatic point_t add_offset(point_t p, offset_t o);
    point_t r;
    r.x = p.x + {{5{o.dx[2]}}, o.dx};
    r.y = p.y + {{5{o.dy[2]}}, o.dy};
    return r;
  endfunction

endpackage

// File: rtl/current_tile_mem_if.sv
// Set-strobe bus between the rotate/move executors, the spawner and the tile
// state holder, plus the expanded tile state returned to them.
interface current_tile_mem_if;
  import tetris_pkg::*;

  logic         spawn_v_i;
  tile_type_e   spawn_type_i;
  point_t       spawn_pos_i;
  logic         rot_set_v_i;
  tile_type_e   rot_type_i;
  logic [1:0]   rot_angle_i;
  logic         mov_set_v_i;
  point_t       mov_pos_i;

  logic         ready_o;
  tile_type_e   type_o;
  logic [1:0]   angle_o;
  point_t       pos_o;
  point_t [3:0] cells_o;
  logic         tile_v_o;
  logic         oob_o;
  logic         drop_o;

  modport master (
    output spawn_v_i, spawn_type_i, spawn_pos_i,
           rot_set_v_i, rot_type_i, rot_angle_i,
           mov_set_v_i, mov_pos_i,
    input  ready_o, type_o, angle_o, pos_o, cells_o, tile_v_o, oob_o, drop_o
  );

  modport slave (
    input  spawn_v_i, spawn_type_i, spawn_pos_i,
           rot_set_v_i, rot_type_i, rot_angle_i,
           mov_set_v_i, mov_pos_i,
    output ready_o, type_o, angle_o, pos_o, cells_o, tile_v_o, oob_o, drop_o
  );
endinterface

// File: rtl/tile_shape_rom.sv
// Combinational lookup of one cell offset of a tile at a given rotation.
module tile_shape_rom
  import tetris_pkg::*;
(
  input  tile_type_e tile_type,
  input  logic [1:0] angle,
  input  logic [1:0] idx,
  output offset_t    offset
);

  assign offset = tile_cell_offset(tile_type, angle, idx);

endmodule

// File: rtl/current_tile_mem.sv
// Falling-tile state: type, angle and pivot, expanded one cell per cycle into
// absolute board coordinates with an out-of-bounds summary.
module current_tile_mem
  import tetris_pkg::*;
#(
  parameter int width_p  = 16,
  parameter int height_p = 32
) (
  input logic               clk_i,
  input logic               reset_n_i,
  current_tile_mem_if.slave tile_bus
);

  state_e       state_r;
  logic [1:0]   idx_r;
  tile_type_e   type_r;
  logic [1:0]   angle_r;
  point_t       pos_r;
  point_t [3:0] cells_r;
  logic         oob_r;
  logic         drop_r;
  logic         ready_r;

  offset_t      cell_ofs;
  point_t       cell_next;
  logic         cell_oob;
  logic         any_set;
  logic         multi_set;

  tile_shape_rom u_shape_rom (
    .tile_type (type_r),
    .angle     (angle_r),
    .idx       (idx_r),
    .offset    (cell_ofs)
  );

  assign cell_next = add_offset(pos_r, cell_ofs);
  assign cell_oob  = (int'({24'd0, cell_next.x}) >= width_p) ||
                     (int'({24'd0, cell_next.y}) >= height_p);

  assign any_set   = tile_bus.spawn_v_i | tile_bus.rot_set_v_i | tile_bus.mov_set_v_i;
  assign multi_set = (tile_bus.spawn_v_i   & tile_bus.rot_set_v_i) |
                     (tile_bus.spawn_v_i   & tile_bus.mov_set_v_i) |
                     (tile_bus.rot_set_v_i & tile_bus.mov_set_v_i);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r <= eIDLE;
      idx_r   <= 2'd0;
      type_r  <= eNon;
      angle_r <= 2'd0;
      pos_r   <= '0;
      cells_r <= '0;
      oob_r   <= 1'b0;
      drop_r  <= 1'b0;
      ready_r <= 1'b1;
    end else begin
      drop_r <= 1'b0;
      case (state_r)
        eIDLE: begin
          if (any_set) begin
            state_r <= eUPDATE;
            idx_r   <= 2'd0;
            ready_r <= 1'b0;
            oob_r   <= 1'b0;
            // Lower-priority strobes arriving alongside the winner are lost.
            drop_r  <= multi_set;
            if (tile_bus.spawn_v_i) begin
              type_r  <= tile_bus.spawn_type_i;
              angle_r <= 2'd0;
              pos_r   <= tile_bus.spawn_pos_i;
            end else if (tile_bus.rot_set_v_i) begin
              type_r  <= tile_bus.rot_type_i;
              angle_r <= tile_bus.rot_angle_i;
            end else begin
              pos_r   <= tile_bus.mov_pos_i;
            end
          end
        end
        eUPDATE: begin
          cells_r[idx_r] <= cell_next;
          oob_r          <= oob_r | cell_oob;
          idx_r          <= idx_r + 2'd1;
          drop_r         <= any_set;
          if (idx_r == 2'd3) begin
            state_r <= eIDLE;
            ready_r <= 1'b1;
          end
        end
        default: begin
          state_r <= eIDLE;
          ready_r <= 1'b1;
        end
      endcase
    end
  end

  assign tile_bus.ready_o  = ready_r;
  assign tile_bus.type_o   = type_r;
  assign tile_bus.angle_o  = angle_r;
  assign tile_bus.pos_o    = pos_r;
  assign tile_bus.cells_o  = cells_r;
  assign tile_bus.tile_v_o = (type_r != eNon);
  assign tile_bus.oob_o    = oob_r;
  assign tile_bus.drop_o   = drop_r;

endmodule

// File: tb/tb_current_tile_mem.sv
// Bench for current_tile_mem: directed vector table, hand-written corner
// sequences and randomized transactions against a rotation-based shape model.
module tb_current_tile_mem;
  import tetris_pkg::*;

  logic clk;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;

  current_tile_mem_if bus ();

  current_tile_mem #(.width_p(16), .height_p(32)) dut (
    .clk_i     (clk),
    .reset_n_i (rst_n),
    .tile_bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Angle-0 shapes (y down); other angles come from quarter-turn rotation.
  int base_dx [8][4] = '{'{0,0,0,0}, '{-1,0,1,2}, '{0,1,0,1}, '{-1,0,1,0},
                         '{0,1,-1,0}, '{-1,0,0,1}, '{-1,0,1,1}, '{-1,0,1,-1}};
  int base_dy [8][4] = '{'{0,0,0,0}, '{0,0,0,0}, '{0,0,1,1}, '{0,0,0,1},
                         '{0,0,1,1}, '{0,0,1,1}, '{0,0,0,1}, '{0,0,0,1}};

  int m_type, m_angle, m_x, m_y;

  function automatic logic [63:0] model_cells(int t, int a, int x, int y);
    logic [63:0] r;
    int dx, dy, tmp;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      dx = base_dx[t][i];
      dy = base_dy[t][i];
      for (int k = 0; k < a; k++) begin
        tmp = dx; dx = -dy; dy = tmp;
      end
      r[16*i +: 16] = {8'((x + dx) & 255), 8'((y + dy) & 255)};
    end
    return r;
  endfunction

  function automatic logic model_oob(logic [63:0] c);
    logic o;
    o = 1'b0;
    for (int i = 0; i < 4; i++)
      if (c[16*i+8 +: 8] >= 8'd16 || c[16*i +: 8] >= 8'd32) o = 1'b1;
    return o;
  endfunction

  function automatic point_t pt(int x, int y);
    point_t p;
    p.x = 8'(x);
    p.y = 8'(y);
    return p;
  endfunction

  function automatic logic [63:0] c4(int x0, int y0, int x1, int y1, int x2, int y2, int x3, int y3);
    return {pt(x3, y3), pt(x2, y2), pt(x1, y1), pt(x0, y0)};
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_strobes();
    bus.spawn_v_i   = 1'b0;
    bus.rot_set_v_i = 1'b0;
    bus.mov_set_v_i = 1'b0;
  endtask

  task automatic check_reset_state(string tag);
    check({tag, ".ready"},  64'(bus.ready_o),  64'd1);
    check({tag, ".type"},   64'(bus.type_o),   64'(eNon));
    check({tag, ".angle"},  64'(bus.angle_o),  64'd0);
    check({tag, ".pos"},    64'(bus.pos_o),    64'd0);
    check({tag, ".cells"},  bus.cells_o,       64'd0);
    check({tag, ".tile_v"}, 64'(bus.tile_v_o), 64'd0);
    check({tag, ".oob"},    64'(bus.oob_o),    64'd0);
    check({tag, ".drop"},   64'(bus.drop_o),   64'd0);
  endtask

  typedef struct {
    logic       sp;  tile_type_e st; point_t spp;
    logic       ro;  tile_type_e rt; logic [1:0] ra;
    logic       mv;  point_t mp;
    tile_type_e et;  logic [1:0] ea; point_t ep;
    logic [63:0] ec; logic eo; logic ed;
  } vec_t;

  // Applies one set transaction in idle and follows it through the update.
  task automatic run_txn(string tag, vec_t v);
    int lowc;
    bus.spawn_v_i    = v.sp;  bus.spawn_type_i = v.st; bus.spawn_pos_i = v.spp;
    bus.rot_set_v_i  = v.ro;  bus.rot_type_i   = v.rt; bus.rot_angle_i = v.ra;
    bus.mov_set_v_i  = v.mv;  bus.mov_pos_i    = v.mp;
    step();
    clear_strobes();
    check({tag, ".type"},   64'(bus.type_o),   64'(v.et));
    check({tag, ".angle"},  64'(bus.angle_o),  64'(v.ea));
    check({tag, ".pos"},    64'(bus.pos_o),    64'(v.ep));
    check({tag, ".ready1"}, 64'(bus.ready_o),  64'd0);
    check({tag, ".drop"},   64'(bus.drop_o),   64'(v.ed));
    check({tag, ".tile_v"}, 64'(bus.tile_v_o), 64'(v.et != eNon));
    lowc = 0;
    while (bus.ready_o !== 1'b1 && lowc < 12) begin
      lowc++;
      step();
      if (lowc == 1) check({tag, ".cell0_early"}, 64'(bus.cells_o[0]), 64'(v.ec[15:0]));
    end
    check({tag, ".busy_cycles"}, 64'(lowc), 64'd4);
    check({tag, ".cells"},   bus.cells_o,       v.ec);
    check({tag, ".oob"},     64'(bus.oob_o),    64'(v.eo));
    check({tag, ".drop_end"}, 64'(bus.drop_o),  64'd0);
    $display("%s: type=%0d angle=%0d pos=(%0d,%0d) cells=%h oob=%0b busy=%0d",
             tag, bus.type_o, bus.angle_o, bus.pos_o.x, bus.pos_o.y, bus.cells_o, bus.oob_o, lowc);
  endtask

  vec_t vecs [9];

  initial begin
    vec_t rv;
    int   r, ns;
    logic [2:0] sel;

    rst_n = 1'b0;
    clear_strobes();
    bus.spawn_type_i = eNon; bus.spawn_pos_i = '0;
    bus.rot_type_i   = eNon; bus.rot_angle_i = 2'd0; bus.mov_pos_i = '0;

    vecs[0] = '{1'b1, eT,   pt(7,0),   1'b0, eNon, 2'd0, 1'b0, pt(0,0),
                eT,   2'd0, pt(7,0),   c4(6,0, 7,0, 8,0, 7,1),          1'b0, 1'b0};
    vecs[1] = '{1'b0, eNon, pt(0,0),   1'b1, eT,   2'd1, 1'b0, pt(0,0),
                eT,   2'd1, pt(7,0),   c4(7,255, 7,0, 7,1, 6,0),        1'b1, 1'b0};
    vecs[2] = '{1'b1, eI,   pt(3,5),   1'b0, eNon, 2'd0, 1'b1, pt(9,9),
                eI,   2'd0, pt(3,5),   c4(2,5, 3,5, 4,5, 5,5),          1'b0, 1'b1};
    vecs[3] = '{1'b0, eNon, pt(0,0),   1'b0, eNon, 2'd0, 1'b1, pt(15,31),
                eI,   2'd0, pt(15,31), c4(14,31, 15,31, 16,31, 17,31),  1'b1, 1'b0};
    vecs[4] = '{1'b0, eNon, pt(0,0),   1'b1, eO,   2'd2, 1'b1, pt(1,1),
                eO,   2'd2, pt(15,31), c4(15,31, 14,31, 15,30, 14,30),  1'b0, 1'b1};
    vecs[5] = '{1'b1, eNon, pt(200,3), 1'b1, eZ,   2'd3, 1'b0, pt(0,0),
                eNon, 2'd0, pt(200,3), c4(200,3, 200,3, 200,3, 200,3),  1'b1, 1'b1};
    vecs[6] = '{1'b1, eL,   pt(0,0),   1'b0, eNon, 2'd0, 1'b0, pt(0,0),
                eL,   2'd0, pt(0,0),   c4(255,0, 0,0, 1,0, 255,1),      1'b1, 1'b0};
    vecs[7] = '{1'b0, eNon, pt(0,0),   1'b1, eS,   2'd3, 1'b0, pt(0,0),
                eS,   2'd3, pt(0,0),   c4(0,0, 0,255, 1,1, 1,0),        1'b1, 1'b0};
    vecs[8] = '{1'b0, eNon, pt(0,0),   1'b0, eNon, 2'd0, 1'b1, pt(10,10),
                eS,   2'd3, pt(10,10), c4(10,10, 10,9, 11,11, 11,10),   1'b0, 1'b0};

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    step();
    check_reset_state("reset");
    $display("reset: ready=%0b type=%0d cells=%h", bus.ready_o, bus.type_o, bus.cells_o);

    for (int i = 0; i < 9; i++) run_txn($sformatf("vec%0d", i), vecs[i]);

    m_type = 4; m_angle = 3; m_x = 10; m_y = 10;

    // A move strobe arriving mid-update is discarded.
    bus.mov_set_v_i = 1'b1; bus.mov_pos_i = pt(4,4);
    step();
    clear_strobes();
    m_x = 4; m_y = 4;
    step();
    bus.mov_set_v_i = 1'b1; bus.mov_pos_i = pt(50,50);
    step();
    clear_strobes();
    check("busy_drop.pulse", 64'(bus.drop_o), 64'd1);
    step();
    check("busy_drop.pulse_end", 64'(bus.drop_o), 64'd0);
    check("busy_drop.ready_t4", 64'(bus.ready_o), 64'd0);
    step();
    check("busy_drop.ready_t5", 64'(bus.ready_o), 64'd1);
    check("busy_drop.pos", 64'(bus.pos_o), 64'(pt(4,4)));
    check("busy_drop.cells", bus.cells_o, model_cells(m_type, m_angle, m_x, m_y));
    $display("busy_drop: pos=(%0d,%0d) cells=%h drop seen, ready back at t+5",
             bus.pos_o.x, bus.pos_o.y, bus.cells_o);

    // Reset asserted while idx_r=2 must restore reset values at once.
    bus.spawn_v_i = 1'b1; bus.spawn_type_i = eJ; bus.spawn_pos_i = pt(5,5);
    step();
    clear_strobes();
    step();
    step();
    rst_n = 1'b0;
    #1;
    check_reset_state("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("mid_reset.ready_after", 64'(bus.ready_o), 64'd1);
    $display("mid_reset: type=%0d pos=(%0d,%0d) cells=%h ready=%0b",
             bus.type_o, bus.pos_o.x, bus.pos_o.y, bus.cells_o, bus.ready_o);
    m_type = 0; m_angle = 0; m_x = 0; m_y = 0;

    for (int n = 0; n < 60; n++) begin
      r = int'($urandom_range(0, 9));
      if (r < 3)      sel = 3'b100;
      else if (r < 6) sel = 3'b010;
      else if (r < 9) sel = 3'b001;
      else            sel = 3'($urandom_range(3, 7));
      rv.sp  = sel[2]; rv.ro = sel[1]; rv.mv = sel[0];
      rv.st  = tile_type_e'($urandom_range(0, 7));
      rv.rt  = tile_type_e'($urandom_range(0, 7));
      rv.ra  = 2'($urandom_range(0, 3));
      rv.spp = pt(($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 17)),
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 33)));
      rv.mp  = pt(($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 17)),
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 33)));
      if (rv.sp) begin
        m_type = int'(rv.st); m_angle = 0; m_x = int'(rv.spp.x); m_y = int'(rv.spp.y);
      end else if (rv.ro) begin
        m_type = int'(rv.rt); m_angle = int'(rv.ra);
      end else begin
        m_x = int'(rv.mp.x); m_y = int'(rv.mp.y);
      end
      ns = int'(rv.sp) + int'(rv.ro) + int'(rv.mv);
      rv.et = tile_type_e'(m_type);
      rv.ea = 2'(m_angle);
      rv.ep = pt(m_x, m_y);
      rv.ec = model_cells(m_type, m_angle, m_x, m_y);
      rv.eo = model_oob(rv.ec);
      rv.ed = (ns > 1);
      run_txn($sformatf("rand%0d", n), rv);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/current_tile_mem.md
Name: current_tile_mem

Overview:
- Holds the state of the falling tile: type, angle and pivot position. Expands that state into 4 absolute cell coordinates for the collision checker and renderer.
- Sits directly downstream of the rotate/move executors and the tile spawner.
- Consumes their set strobes and returns the ready handshake that the executors wait on before finishing.

Parameters:
- width_p, 16, board width in cells; used for the out-of-bounds flag.
- height_p, 32, board height in cells; used for the out-of-bounds flag.

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  asynchronous active-low reset
- spawn_v_i  in  1  spawn strobe; loads type, pos, angle=0
- spawn_type_i  in  tile_type_e  new tile type
- spawn_pos_i  in  point_t  new pivot
- rot_set_v_i  in  1  rotate executor set strobe
- rot_type_i  in  tile_type_e  type from rotate executor
- rot_angle_i  in  2  new angle from rotate executor
- mov_set_v_i  in  1  move executor set strobe
- mov_pos_i  in  point_t  new pivot from move executor
- ready_o  out  1  idle; update accepted and cells consistent
- type_o  out  tile_type_e  current type
- angle_o  out  2  current angle
- pos_o  out  point_t  current pivot
- cells_o  out  4 x point_t  absolute cell coordinates
- tile_v_o  out  1  type_o != eNon
- oob_o  out  1  any cell outside the board
- drop_o  out  1  one-cycle pulse: a set strobe was discarded

Behaviour:
- Reset (async, reset_n_i low), all outputs:
  - state eIDLE
  - type_o=eNon, angle_o=0, pos_o=0
  - cells_o all 0, oob_o=0, drop_o=0
  - ready_o=1 once reset is released
- States: eIDLE and eUPDATE, with a 2-bit cell index idx_r.
- eIDLE, ready_o=1:
  - Any set strobe is accepted at the clock edge and the FSM moves to eUPDATE with idx_r=0.
  - Priority is spawn > rotate > move; only the highest-priority strobe is applied.
- Register updates:
  - spawn: type<=spawn_type_i, angle<=0, pos<=spawn_pos_i.
  - rotate: type<=rot_type_i, angle<=rot_angle_i; pos unchanged.
  - move: pos<=mov_pos_i; type and angle unchanged.
- type_o, angle_o and pos_o change the cycle after acceptance (t+1).
- eUPDATE, ready_o=0:
  - One cell per cycle: cells_o[idx_r] <= pos + offset(type, angle, idx_r).
  - idx_r increments each cycle; after idx_r=3 the FSM returns to eIDLE.
- Timing: strobe accepted at edge t; ready_o low t+1..t+4; cells_o[k] valid from t+2+k; ready_o high again at t+5.
- Executor compatibility: an executor that asserts set for one cycle and then waits for ready sees ready_o=0 on its first waiting cycle.
- Arithmetic:
  - Offsets are signed 3-bit, sign-extended to point_t width; addition is modulo 2^8 per axis.
  - Negative results wrap to large unsigned values and are caught by oob.
- Out-of-bounds flag:
  - oob_o clears on acceptance.
  - Per cell, oob_o |= (x >= width_p) | (y >= height_p).
  - oob_o is final when ready_o rises.
- type eNon: all offsets are 0, so all cells equal pos; tile_v_o=0.
- Drop cases, each giving a drop_o pulse the next cycle with no state change:
  - any set strobe while in eUPDATE;
  - the losing strobes of a simultaneous arbitration in eIDLE.
- Rotate with rot_type_i differing from the current type: the type is overwritten; no check.
- Reset mid-update: returns immediately to the reset values; the partial cell update is lost.

Decomposition:
- Package tetris:
  - tile_type_e and point_t (8-bit x, 8-bit y).
  - offset_t (signed 3-bit dx, dy).
  - Constant shape table indexed [type][angle][idx], plus function tile_cell_offset(type, angle, idx).
- Sub-module tile_shape_rom: combinational lookup from (type, angle, idx) to offset_t, wrapping the package table.
- T-piece table rows (y grows downward):
  - angle0: (-1,0)(0,0)(1,0)(0,1)
  - angle1: (0,-1)(0,0)(0,1)(-1,0)

Test Plan:
- Reset with no strobes -> ready_o=1, type_o=eNon, tile_v_o=0, cells_o all (0,0), oob_o=0.
- spawn_v_i, eT at (7,0) -> type and pos at t+1; ready_o low for 4 cycles; final cells (6,0)(7,0)(8,0)(7,1); oob_o=0.
- From that state, rot_set_v_i with eT, angle 1 -> cells (7,255)(7,0)(7,1)(6,0); oob_o=1 (y=255 >= 32); pos unchanged.
- Same cycle spawn_v_i and mov_set_v_i -> spawn applied, pos_o=spawn_pos_i; drop_o pulses once at t+1.
- mov_set_v_i two cycles into eUPDATE -> ignored, drop_o pulse, pos_o unchanged, ready_o returns at t+5 as normal.
- reset_n_i low during eUPDATE (idx_r=2) -> outputs immediately at reset values; ready_o=1 after release.
